saa_psg: RTL
============

// Module: saa_psg
// PURPOSE
//  Parametrised SAA1099-compatible programmable sound generator: CPU-write register file, CHANNELS square-wave
//  tone generators with 3-bit octave/8-bit frequency, per-channel 4-bit L/R amplitude, summed to stereo PCM.
//  Sits on the Z80 I/O decode (two ports: data, address) and feeds the audio mixer/DAC at clk_sys, ce=8 MHz.
// PARAMETERS
//  CHANNELS  6  tone channels, legal 1..6; register writes addressing channels >= CHANNELS are ignored
//  OUT_W     8  width of out_l/out_r, legal 8..16
// PORTS
//  clk_sys  in   1      system clock; all state on rising edge
//  rst_n    in   1      asynchronous active-low reset
//  ce       in   1      8 MHz clock enable; all sound generation advances only on ce=1 cycles
//  cs_n     in   1      chip select, active low
//  a0       in   1      0=data write, 1=address write
//  wr_n     in   1      write strobe, active low
//  din      in   8      CPU data bus
//  out_l    out  OUT_W  left PCM, unsigned, registered
//  out_r    out  OUT_W  right PCM, unsigned, registered
// BEHAVIOUR
//  Reset: all registers, address latch, counters, square bits, prescaler = 0; LFSRs = 17'h1FFFF; outputs = 0.
//  Bus: write event = first clk_sys cycle with cs_n=0 & wr_n=0 after a cycle without (one event per strobe,
//   independent of ce). a0=1: addr <= din[4:0]. a0=0: reg[addr] <= din. No auto-increment; undefined addr ignored.
//  Map: 00-05 amp ch n (din[3:0]=R, din[7:4]=L); 08-0D freq ch n; 10-12 octave (din[2:0]=ch 2k, din[6:4]=ch 2k+1);
//   14 tone enable bit n; 15 noise enable bit n; 16 noise clk (din[1:0]=gen0, din[5:4]=gen1);
//   1C bit0 sound enable, bit1 sync reset.
//  Prescaler: 8-bit pre increments on every ce cycle, wraps 255->0.
//  Tone tick ch n: ce cycle where pre[7-oct:0] all ones -> period 2^(8-oct) ce (oct=7 ->2, oct=0 ->256).
//   On tick: if cnt==255 {cnt<=freq; sq<=~sq; emit 1-cycle toggle pulse} else cnt<=cnt+1.
//   Half-period = (256-freq)*2^(8-oct) ce cycles. Freq/octave writes take effect at the next reload only.
//  Sync reset (1C bit1=1): every cnt<=freq, sq<=0, LFSRs hold; released on the first ce after the bit clears.
//  Sound enable=0: out_l/out_r forced 0 on next ce; generators keep running.
//  Mixer per channel: sig = tone_en&noise_en ? sq&nz : tone_en ? sq : noise_en ? nz : 0.
//   sumL = sum of (sig ? ampL : 0); sumR likewise (max 6*15=90). out = min(sum<<1, 2^OUT_W-1), zero-extended,
//   registered on ce; latency 1 ce from generator state to output.
//  Simultaneous: write to a register during its use -> new value used from the following ce. Async reset
//   mid-operation returns everything to reset values immediately; no partial write survives.
// CONFIGURATION
//  SAA_PSG_NOISE_EN defined: two 17-bit Fibonacci LFSRs (taps 17,14; shift in XNOR... no: XOR, out = bit0).
//   gen0 serves ch 0-2, gen1 ch 3-5. Clock sel: 00 = pre==255 (ce/256), 01 = every 512 ce, 10 = every 1024 ce,
//   11 = toggle pulse of ch0 (gen0) / ch3 (gen1; if CHANNELS<4, never clocks).
//  Not defined: no LFSRs; nz=0, reg 15/16 writes ignored, mixer reduces to sig = tone_en & sq.
// TESTING
//  Write 0x1C=0x01, 0x00=0xF8 (L=15? no: L=0xF, R=0x8), 0x08=0xFE, 0x10=0x07, 0x14=0x01 -> out_l toggles 0/30,
//   out_r 0/16, half-period 4 ce cycles.
//  oct=0, freq=0 on ch1 -> sq1 toggles every 65536 ce cycles exactly.
//  All 6 channels amp 0xFF, tone on, sync phase -> sumL=90, out_l=180; OUT_W=8 no saturation; force CHANNELS=6,
//   OUT_W=8 with amp doubled path check saturation at 255 using out<<1 model.
//  Hold wr_n low 10 clk_sys with a0=1, din=0x08 then one a0=0 write -> exactly one register write occurs.
//  Set 1C=0x03 mid-tone -> all sq=0, outputs 0; clear to 0x01 -> first toggle after (256-freq)*2^(8-oct) ce.
//  With SAA_PSG_NOISE_EN: noise sel 00, 0x15=0x01, 0x14=0 -> ch0 output changes only on pre==255 cycles;
//   without macro -> out stays 0.

Source files
------------

// File: rtl/saa_psg.sv
// -----------------------------------------------------------------------------
// saa_psg -- SAA1099-compatible programmable sound generator
//
// A CPU writes an address latch (a0=1) and then the addressed register (a0=0).
// CHANNELS square-wave tone generators (3-bit octave, 8-bit frequency) are
// mixed with per-channel 4-bit left/right amplitudes into unsigned stereo PCM.
// All sound generation advances only on cycles where ce=1.
//
// Optional feature macro: SAA_PSG_NOISE_EN
//   Defined     : two 17-bit LFSR noise generators (gen0 -> ch 0-2,
//                 gen1 -> ch 3-5), noise enable (0x15) and noise clock
//                 select (0x16) registers are live.
//   Not defined : no noise hardware; writes to 0x15/0x16 are ignored and the
//                 mixer reduces to tone_en & square.
//
// Parameters
//   CHANNELS  number of tone channels, 1..6
//   OUT_W     width of out_l/out_r, 8..16
//
// Ports
//   clk_sys  in   system clock, all state on the rising edge
//   rst_n    in   asynchronous active-low reset
//   ce       in   sound-generation clock enable
//   cs_n     in   chip select, active low
//   a0       in   0 = data write, 1 = address write
//   wr_n     in   write strobe, active low
//   din      in   CPU data bus
//   out_l    out  left PCM, unsigned, registered
//   out_r    out  right PCM, unsigned, registered
// -----------------------------------------------------------------------------
module saa_psg #(
  parameter int CHANNELS = 6,
  parameter int OUT_W    = 8
) (
  input  logic             clk_sys,
  input  logic             rst_n,
  input  logic             ce,
  input  logic             cs_n,
  input  logic             a0,
  input  logic             wr_n,
  input  logic [7:0]       din,
  output logic [OUT_W-1:0] out_l,
  output logic [OUT_W-1:0] out_r
);

  localparam int NMAX = 6;
  // Only bits of implemented channels can ever be set in enable registers.
  localparam logic [NMAX-1:0] CH_MASK = NMAX'((7'd1 << CHANNELS) - 7'd1);
  localparam logic [16:0]     OUT_MAX = 17'((1 << OUT_W) - 1);

`ifdef SAA_PSG_NOISE_EN
  // Two extra prescaler bits provide the /512 and /1024 noise clocks.
  localparam int PRE_W = 10;
`else
  localparam int PRE_W = 8;
`endif

  // ---------------------------------------------------------------------------
  // Register file and bus interface
  // ---------------------------------------------------------------------------
  logic            r_wr_prev;
  logic            w_wr_act;
  logic            w_wr_evt;
  logic [4:0]      r_addr;
  logic [3:0]      r_amp_l [NMAX];
  logic [3:0]      r_amp_r [NMAX];
  logic [7:0]      r_freq  [NMAX];
  logic [2:0]      r_oct   [NMAX];
  logic [NMAX-1:0] r_tone_en;
  logic            r_snd_en;
  logic            r_sync;
`ifdef SAA_PSG_NOISE_EN
  logic [NMAX-1:0] r_noise_en;
  logic [1:0]      r_nsel [2];
`endif

  // A write event is the first cycle of an active strobe, so a strobe held
  // for many clocks (or whose bus changes while held) writes only once.
  assign w_wr_act = ~cs_n & ~wr_n;
  assign w_wr_evt = w_wr_act & ~r_wr_prev;

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_prev <= 1'b0;
      r_addr    <= '0;
      for (int i = 0; i < NMAX; i++) begin
        r_amp_l[i] <= '0;
        r_amp_r[i] <= '0;
        r_freq[i]  <= '0;
        r_oct[i]   <= '0;
      end
      r_tone_en <= '0;
      r_snd_en  <= 1'b0;
      r_sync    <= 1'b0;
`ifdef SAA_PSG_NOISE_EN
      r_noise_en <= '0;
      r_nsel[0]  <= '0;
      r_nsel[1]  <= '0;
`endif
    end else begin
      r_wr_prev <= w_wr_act;
      if (w_wr_evt) begin
        if (a0) begin
          r_addr <= din[4:0];
        end else begin
          for (int i = 0; i < CHANNELS; i++) begin
            if (r_addr == 5'(i)) begin
              r_amp_l[i] <= din[7:4];
              r_amp_r[i] <= din[3:0];
            end
            if (r_addr == 5'(8 + i)) begin
              r_freq[i] <= din;
            end
            // Octave registers pack two channels: even in [2:0], odd in [6:4].
            if (r_addr == 5'(16 + i / 2)) begin
              r_oct[i] <= (i % 2 == 0) ? din[2:0] : din[6:4];
            end
          end
          if (r_addr == 5'h14) begin
            r_tone_en <= din[NMAX-1:0] & CH_MASK;
          end
`ifdef SAA_PSG_NOISE_EN
          if (r_addr == 5'h15) begin
            r_noise_en <= din[NMAX-1:0] & CH_MASK;
          end
          if (r_addr == 5'h16) begin
            r_nsel[0] <= din[1:0];
            r_nsel[1] <= din[5:4];
          end
`endif
          if (r_addr == 5'h1C) begin
            r_snd_en <= din[0];
            r_sync   <= din[1];
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Tone generators
  // ---------------------------------------------------------------------------
  logic [PRE_W-1:0] r_pre;
  logic [7:0]       r_cnt     [NMAX];
  logic [2:0]       r_oct_act [NMAX];  // octave in force since the last reload
  logic [NMAX-1:0]  r_sq;
  logic [7:0]       w_mask    [NMAX];
  logic [NMAX-1:0]  w_tick;
  logic [NMAX-1:0]  w_tog;

  // A channel ticks when the low (8-oct) prescaler bits are all ones, giving
  // a tick period of 2^(8-oct) ce cycles.
  always_comb begin
    for (int i = 0; i < NMAX; i++) begin
      w_mask[i] = 8'((9'd1 << (4'd8 - {1'b0, r_oct_act[i]})) - 9'd1);
      w_tick[i] = ce && (i < CHANNELS) && !r_sync &&
                  ((r_pre[7:0] & w_mask[i]) == w_mask[i]);
      w_tog[i]  = w_tick[i] && (r_cnt[i] == 8'hFF);
    end
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_pre <= '0;
      r_sq  <= '0;
      for (int i = 0; i < NMAX; i++) begin
        r_cnt[i]     <= '0;
        r_oct_act[i] <= '0;
      end
    end else begin
      // Sync reset also parks the prescaler so that after release every
      // channel's first half-period is exactly (256-freq)*2^(8-oct) ce.
      if (r_sync) begin
        r_pre <= '0;
      end else if (ce) begin
        r_pre <= r_pre + PRE_W'(1);
      end
      for (int i = 0; i < NMAX; i++) begin
        if (r_sync) begin
          r_cnt[i]     <= r_freq[i];
          r_oct_act[i] <= r_oct[i];
          r_sq[i]      <= 1'b0;
        end else if (w_tog[i]) begin
          // Frequency and octave changes only land here, at the reload.
          r_cnt[i]     <= r_freq[i];
          r_oct_act[i] <= r_oct[i];
          r_sq[i]      <= ~r_sq[i];
        end else if (w_tick[i]) begin
          r_cnt[i] <= r_cnt[i] + 8'd1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Noise generators and per-channel signal select
  // ---------------------------------------------------------------------------
  logic [NMAX-1:0] w_sig;

`ifdef SAA_PSG_NOISE_EN
  logic [16:0] r_lfsr [2];
  logic [1:0]  w_nclk;
  logic        w_nz;

  always_comb begin
    for (int g = 0; g < 2; g++) begin
      case (r_nsel[g])
        2'b00:   w_nclk[g] = ce && (r_pre[7:0] == 8'hFF);
        2'b01:   w_nclk[g] = ce && (r_pre[8:0] == 9'h1FF);
        2'b10:   w_nclk[g] = ce && (r_pre == 10'h3FF);
        // Select 11 follows the ch0/ch3 toggle pulse; w_tog[3] stays low if CHANNELS < 4.
        default: w_nclk[g] = (g == 0) ? w_tog[0] : w_tog[3];
      endcase
    end
  end

  // Fibonacci LFSR, taps 17 and 14: the output is bit 0 (stage 17), the
  // feedback of stages 17 and 14 enters at bit 16.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr[0] <= 17'h1FFFF;
      r_lfsr[1] <= 17'h1FFFF;
    end else begin
      for (int g = 0; g < 2; g++) begin
        if (!r_sync && w_nclk[g]) begin
          r_lfsr[g] <= {r_lfsr[g][0] ^ r_lfsr[g][3], r_lfsr[g][16:1]};
        end
      end
    end
  end

  always_comb begin
    w_nz = 1'b0;
    for (int i = 0; i < NMAX; i++) begin
      w_nz = (i < 3) ? r_lfsr[0][0] : r_lfsr[1][0];
      if (r_tone_en[i] && r_noise_en[i]) begin
        w_sig[i] = r_sq[i] & w_nz;
      end else if (r_tone_en[i]) begin
        w_sig[i] = r_sq[i];
      end else if (r_noise_en[i]) begin
        w_sig[i] = w_nz;
      end else begin
        w_sig[i] = 1'b0;
      end
    end
  end
`else
  assign w_sig = r_tone_en & r_sq;
`endif

  // ---------------------------------------------------------------------------
  // Stereo mixer and output registers
  // ---------------------------------------------------------------------------
  logic [7:0]       w_sum_l;
  logic [7:0]       w_sum_r;
  logic [8:0]       w_dbl_l;
  logic [8:0]       w_dbl_r;
  logic [OUT_W-1:0] w_mix_l;
  logic [OUT_W-1:0] w_mix_r;

  always_comb begin
    w_sum_l = '0;
    w_sum_r = '0;
    for (int i = 0; i < NMAX; i++) begin
      if (w_sig[i]) begin
        w_sum_l = w_sum_l + {4'd0, r_amp_l[i]};
        w_sum_r = w_sum_r + {4'd0, r_amp_r[i]};
      end
    end
    w_dbl_l = {w_sum_l, 1'b0};
    w_dbl_r = {w_sum_r, 1'b0};
    w_mix_l = ({8'd0, w_dbl_l} > OUT_MAX) ? OUT_MAX[OUT_W-1:0] : OUT_W'(w_dbl_l);
    w_mix_r = ({8'd0, w_dbl_r} > OUT_MAX) ? OUT_MAX[OUT_W-1:0] : OUT_W'(w_dbl_r);
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      out_l <= '0;
      out_r <= '0;
    end else if (ce) begin
      out_l <= r_snd_en ? w_mix_l : '0;
      out_r <= r_snd_en ? w_mix_r : '0;
    end
  end

endmodule
